// File: rtl/timing_sequencer.sv
// Four-quarter, multi-slot timing sequencer with registered clock enables.
// Optional hold feature: define TIMING_SEQ_STALL_EN to add the stall input.
module timing_sequencer #(
  parameter int SLOTS        = 8,
  parameter int PHASE_CYCLES = 2
) (
  input  logic                     sysclk,
  input  logic                     poc,
`ifdef TIMING_SEQ_STALL_EN
  input  logic                     stall,
`endif
  output logic                     clk1,
  output logic                     clk2,
  output logic [SLOTS-1:0]         slot,
  output logic [$clog2(SLOTS)-1:0] slot_idx,
  output logic                     sync,
  output logic                     cycle_start
);

  localparam int IW = $clog2(SLOTS);
  localparam int CW = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
  localparam logic [CW-1:0] C_LAST = CW'(PHASE_CYCLES - 1);
  localparam logic [IW-1:0] I_LAST = IW'(SLOTS - 1);
  localparam logic [IW-1:0] I_PRE  = IW'(SLOTS - 2);

  logic             w_stall;
  logic             r_run;
  logic [1:0]       r_q;
  logic [CW-1:0]    r_c;
  logic [SLOTS-1:0] r_slot;
  logic [IW-1:0]    r_idx;
  logic             r_sync;
  logic             r_cs;
  logic             r_clk1;
  logic             r_clk2;

  logic [1:0]       w_q;
  logic [CW-1:0]    w_c;
  logic [SLOTS-1:0] w_slot;
  logic [IW-1:0]    w_idx;
  logic             w_sync;
  logic             w_cs;
  logic             w_clk1;
  logic             w_clk2;
  logic             w_end;
  logic             w_onehot;

`ifdef TIMING_SEQ_STALL_EN
  assign w_stall = stall;
`else
  assign w_stall = 1'b0;
`endif

  // State register; reset parks the counters at the end of Q3 (pre-start).
  always_ff @(posedge sysclk or posedge poc) begin
    if (poc) begin
      r_run  <= 1'b0;
      r_q    <= 2'd3;
      r_c    <= C_LAST;
      r_slot <= SLOTS'(1);
      r_idx  <= '0;
      r_sync <= 1'b0;
      r_cs   <= 1'b0;
      r_clk1 <= 1'b0;
      r_clk2 <= 1'b0;
    end else begin
      r_run  <= 1'b1;
      r_q    <= w_q;
      r_c    <= w_c;
      r_slot <= w_slot;
      r_idx  <= w_idx;
      r_sync <= w_sync;
      r_cs   <= w_cs;
      r_clk1 <= w_clk1;
      r_clk2 <= w_clk2;
    end
  end

  // Next-state logic
  always_comb begin
    w_end    = (r_q == 2'd3) && (r_c == C_LAST);
    w_onehot = (|r_slot) &&
               ((r_slot & (r_slot - 1'b1)) == '0);
    w_q      = r_q;
    w_c      = r_c;
    w_slot   = r_slot;
    w_idx    = r_idx;
    w_sync   = r_sync;
    w_cs     = 1'b0;
    if (!r_run) begin
      w_q    = 2'd0;
      w_c    = '0;
      w_slot = SLOTS'(1);
      w_idx  = '0;
      w_sync = 1'b0;
      w_cs   = 1'b1;
    end else if (w_end) begin
      w_q = 2'd0;
      w_c = '0;
      if (!w_onehot) begin
        w_slot = SLOTS'(1);
        w_idx  = '0;
        w_sync = 1'b0;
        w_cs   = 1'b1;
      end else if (!w_stall) begin
        w_slot = {r_slot[SLOTS-2:0], r_slot[SLOTS-1]};
        w_idx  = (r_idx == I_LAST) ? '0 : r_idx + 1'b1;
        w_sync = (r_idx == I_PRE);
        w_cs   = (r_idx == I_LAST);
      end
    end else if (r_c == C_LAST) begin
      w_c = '0;
      w_q = r_q + 2'd1;
    end else begin
      w_c = r_c + 1'b1;
    end
  end

  // Output decode of the upcoming quarter
  always_comb begin
    w_clk1 = (w_q == 2'd0);
    w_clk2 = (w_q == 2'd2);
  end

  assign clk1        = r_clk1;
  assign clk2        = r_clk2;
  assign slot        = r_slot;
  assign slot_idx    = r_idx;
  assign sync        = r_sync;
  assign cycle_start = r_cs;

endmodule

// File: tb/tb_timing_sequencer.sv
// Bench for timing_sequencer: default and SLOTS=4/PHASE_CYCLES=1 instances
// against a time-arithmetic reference model.
module tb_timing_sequencer;

  typedef struct packed {
    bit run;
    int t;
    int idx;
    bit cs;
    bit sync;
    bit heal;
  } mdl_t;

  logic clk = 1'b0;
  logic poc_a = 1'b1;
  logic poc_b = 1'b1;
  logic stall_a = 1'b0;
  logic stall_b = 1'b0;

  logic       a_clk1, a_clk2, a_sync, a_cs;
  logic [7:0] a_slot;
  logic [2:0] a_idx;
  logic       b_clk1, b_clk2, b_sync, b_cs;
  logic [3:0] b_slot;
  logic [1:0] b_idx;

  int n_cmp = 0;
  int n_bad = 0;
  mdl_t ma, mb;

  always #5 clk = ~clk;

  timing_sequencer u_a (
    .sysclk(clk),
    .poc(poc_a),
`ifdef TIMING_SEQ_STALL_EN
    .stall(stall_a),
`endif
    .clk1(a_clk1),
    .clk2(a_clk2),
    .slot(a_slot),
    .slot_idx(a_idx),
    .sync(a_sync),
    .cycle_start(a_cs)
  );

  timing_sequencer #(.SLOTS(4), .PHASE_CYCLES(1)) u_b (
    .sysclk(clk),
    .poc(poc_b),
`ifdef TIMING_SEQ_STALL_EN
    .stall(stall_b),
`endif
    .clk1(b_clk1),
    .clk2(b_clk2),
    .slot(b_slot),
    .slot_idx(b_idx),
    .sync(b_sync),
    .cycle_start(b_cs)
  );

  function automatic mdl_t mrst();
    mdl_t m;
    m = '0;
    return m;
  endfunction

  // t counts sysclk edges since start; subcycle boundaries every 4*P edges
  function automatic mdl_t madv(mdl_t m, int S, int P, bit stl);
    mdl_t n;
    n = m;
    if (!m.run) begin
      n = '0;
      n.run = 1'b1;
      n.cs = 1'b1;
      return n;
    end
    n.t = m.t + 1;
    n.cs = 1'b0;
    if (n.t % (4 * P) == 0) begin
      if (m.heal) begin
        n.idx = 0;
        n.cs = 1'b1;
        n.sync = 1'b0;
        n.heal = 1'b0;
      end else if (!stl) begin
        n.idx = (m.idx + 1) % S;
        n.cs = (n.idx == 0);
        n.sync = (n.idx == S - 1);
      end
    end
    return n;
  endfunction

  task automatic cmp(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check(string tg, mdl_t m, int P,
                       logic c1, logic c2, logic [15:0] sl,
                       logic [3:0] si, logic sy, logic cs);
    int q;
    q = m.run ? (m.t % (4 * P)) / P : 1;
    cmp({tg, ".clk1"}, 32'(c1), 32'(q == 0));
    cmp({tg, ".clk2"}, 32'(c2), 32'(q == 2));
    cmp({tg, ".excl"}, 32'(c1 & c2), 32'(0));
    if (!m.heal)
      cmp({tg, ".slot"}, 32'(sl), 32'(1) << m.idx);
    cmp({tg, ".idx"}, 32'(si), 32'(m.idx));
    cmp({tg, ".sync"}, 32'(sy), 32'(m.sync));
    cmp({tg, ".cs"}, 32'(cs), 32'(m.cs));
  endtask

  task automatic chk_a();
    check("A", ma, 2, a_clk1, a_clk2, 16'(a_slot),
          4'(a_idx), a_sync, a_cs);
  endtask

  task automatic chk_b();
    check("B", mb, 1, b_clk1, b_clk2, 16'(b_slot),
          4'(b_idx), b_sync, b_cs);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    ma = poc_a ? mrst() : madv(ma, 8, 2, stall_a);
    mb = poc_b ? mrst() : madv(mb, 4, 1, stall_b);
    chk_a();
    chk_b();
  endtask

  task automatic restart_a();
    @(negedge clk);
    poc_a = 1'b1;
    tick();
    @(negedge clk);
    poc_a = 1'b0;
  endtask

  initial begin
    ma = mrst();
    mb = mrst();
    repeat (3) tick();
    @(negedge clk);
    poc_a = 1'b0;
    poc_b = 1'b0;

    // Free run from release: fixed edge landmarks
    for (int i = 0; i < 140; i++) begin
      tick();
      if (ma.t == 0) begin
        cmp("e1.cs", 32'(a_cs), 32'(1));
        cmp("e1.slot", 32'(a_slot), 32'h01);
      end
      if (ma.t == 8) cmp("e9.slot", 32'(a_slot), 32'h02);
      if (ma.t == 56) cmp("e57.sync", 32'(a_sync), 32'(1));
      if (ma.t == 64 || ma.t == 128)
        cmp("cs.period", 32'(a_cs), 32'(1));
      if (mb.t == 16) cmp("B.cs16", 32'(b_cs), 32'(1));
    end

    // Asynchronous clear while clk2 is high
    restart_a();
    for (int i = 0; i < 30; i++) tick();
    cmp("e30.clk2", 32'(a_clk2), 32'(1));
    #2;
    poc_a = 1'b1;
    #1;
    ma = mrst();
    cmp("poc.clk2", 32'(a_clk2), 32'(0));
    cmp("poc.slot", 32'(a_slot), 32'h01);
    chk_a();
    @(negedge clk);
    poc_a = 1'b0;
    tick();
    cmp("rst.cs", 32'(a_cs), 32'(1));
    cmp("rst.clk1", 32'(a_clk1), 32'(1));

`ifdef TIMING_SEQ_STALL_EN
    // Stall requested during the last sysclk of slot index 3
    restart_a();
    for (int i = 0; i < 32; i++) tick();
    stall_a = 1'b1;
    tick();
    stall_a = 1'b0;
    for (int i = 0; i < 41; i++) begin
      tick();
      if (ma.t == 39) cmp("st.e40", 32'(a_slot), 32'h08);
      if (ma.t == 40) cmp("st.e41", 32'(a_slot), 32'h10);
      if (ma.t == 64) cmp("st.e65", 32'(a_cs), 32'(0));
      if (ma.t == 72) cmp("st.e73", 32'(a_cs), 32'(1));
    end
`endif

    // Corrupt the slot register and expect self-healing at the next advance
    for (int i = 0; i < 5; i++) tick();
    #2;
    force u_a.r_slot = 8'h05;
    #2;
    release u_a.r_slot;
    ma.heal = 1'b1;
    begin
      int k;
      k = 0;
      while (ma.heal && k < 40) begin
        tick();
        k++;
      end
      cmp("heal.timeout", 32'(ma.heal), 32'(0));
    end
    cmp("heal.slot", 32'(a_slot), 32'h01);
    cmp("heal.idx", 32'(a_idx), 32'(0));
    cmp("heal.cs", 32'(a_cs), 32'(1));

    // Randomised run: stall requests and async clears on B
    for (int i = 0; i < 2000; i++) begin
      tick();
`ifdef TIMING_SEQ_STALL_EN
      stall_a = ($urandom_range(0, 3) == 0);
      stall_b = ($urandom_range(0, 2) == 0);
`endif
      if ($urandom_range(0, 150) == 0) begin
        #2;
        poc_b = 1'b1;
        #1;
        mb = mrst();
        chk_b();
        #1;
        poc_b = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
